// File: rtl/scan_decoder_n_if.sv
// Bus bundle for scan_decoder_n: enables, mode and address load in; decoded select lines and status pulses out.
interface scan_decoder_n_if #(
    parameter int ADDR_W  = 3,
    parameter int NUM_OUT = 8
);
    logic              e1_n;
    logic              e2_n;
    logic              e3;
    logic              mode;
    logic              addr_vld;
    logic [ADDR_W-1:0] addr;
    logic [NUM_OUT-1:0] y_n;
    logic [ADDR_W-1:0] cur_addr;
    logic              wrap;
    logic              addr_err;

    modport master (
        output e1_n, e2_n, e3, mode, addr_vld, addr,
        input  y_n, cur_addr, wrap, addr_err
    );

    modport slave (
        input  e1_n, e2_n, e3, mode, addr_vld, addr,
        output y_n, cur_addr, wrap, addr_err
    );
endinterface

// File: rtl/scan_decoder_n.sv
// Registered active-low one-hot decoder with a direct-address mode and an auto-advancing scan mode.
module scan_decoder_n #(
    parameter int ADDR_W  = 3,
    parameter int NUM_OUT = 8,
    parameter int DWELL   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    scan_decoder_n_if.slave bus
);
    localparam int                CNT_W     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_OUT - 1);
    localparam logic [ADDR_W:0]   NUM_OUT_W = (ADDR_W + 1)'(NUM_OUT);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_run;
    logic [NUM_OUT-1:0]  y_q, y_d;
    logic                wrap_q, wrap_d;
    logic                err_q, err_d;
    logic                en, addr_ok;

    always_comb begin
        en      = ~bus.e1_n & ~bus.e2_n & bus.e3;
        addr_ok = ({1'b0, bus.addr} < NUM_OUT_W);
        state_d = !en ? IDLE : (bus.mode ? SCAN : DIRECT);
        cur_d   = cur_q;
        cnt_d   = '0;
        cnt_run = '0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;
        case (state_d)
            DIRECT: begin
                if (bus.addr_vld) begin
                    if (addr_ok) cur_d = bus.addr;
                    else         err_d = 1'b1;
                end
            end
            SCAN: begin
                // A fresh entry into scan always starts a full dwell period.
                cnt_run = (state_q == SCAN) ? cnt_q : '0;
                if (bus.addr_vld && addr_ok) begin
                    cur_d = bus.addr;
                end else begin
                    err_d = bus.addr_vld;
                    if (cnt_run == CNT_LAST) begin
                        wrap_d = (cur_q == ADDR_LAST);
                        cur_d  = (cur_q == ADDR_LAST) ? '0 : cur_q + 1'b1;
                    end else begin
                        cnt_d = cnt_run + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Decode from the next-state address so y_n and cur_addr update on the same edge.
    for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_dec
        assign y_d[gi] = !((state_d != IDLE) && (cur_d == ADDR_W'(gi)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '1;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bus.y_n      = y_q;
    assign bus.cur_addr = cur_q;
    assign bus.wrap     = wrap_q;
    assign bus.addr_err = err_q;
endmodule

// File: tb/tb_scan_decoder_n.sv
// Bench for scan_decoder_n: an 8-output DWELL=4 instance and a 6-output DWELL=1 instance share one stimulus stream.
module tb_scan_decoder_n;
    logic clk = 1'b0;
    logic rst_n, e1_n, e2_n, e3, mode, vld;
    logic [2:0] addr;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    scan_decoder_n_if #(.ADDR_W(3), .NUM_OUT(8)) ifa ();
    scan_decoder_n_if #(.ADDR_W(3), .NUM_OUT(6)) ifb ();

    assign ifa.e1_n = e1_n;  assign ifb.e1_n = e1_n;
    assign ifa.e2_n = e2_n;  assign ifb.e2_n = e2_n;
    assign ifa.e3 = e3;      assign ifb.e3 = e3;
    assign ifa.mode = mode;  assign ifb.mode = mode;
    assign ifa.addr_vld = vld; assign ifb.addr_vld = vld;
    assign ifa.addr = addr;  assign ifb.addr = addr;

    scan_decoder_n #(.ADDR_W(3), .NUM_OUT(8), .DWELL(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    scan_decoder_n #(.ADDR_W(3), .NUM_OUT(6), .DWELL(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

    // Behavioural reference: position and cycles-held counters per instance.
    int n_out[2] = '{8, 6};
    int dwell[2] = '{4, 1};
    int m_pos[2], m_held[2], m_y[2], m_wrap[2], m_err[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int mask;
            bit en;
            mask = (1 << n_out[i]) - 1;
            m_wrap[i] = 0;
            m_err[i] = 0;
            if (!rst_n) begin
                m_pos[i] = 0;
                m_held[i] = 0;
                m_y[i] = mask;
            end else begin
                en = !e1_n && !e2_n && e3;
                if (!en) begin
                    m_held[i] = 0;
                end else if (!mode) begin
                    m_held[i] = 0;
                    if (vld) begin
                        if (int'(addr) < n_out[i]) m_pos[i] = int'(addr);
                        else m_err[i] = 1;
                    end
                end else if (vld && int'(addr) < n_out[i]) begin
                    m_pos[i] = int'(addr);
                    m_held[i] = 0;
                end else begin
                    m_err[i] = vld ? 1 : 0;
                    m_held[i]++;
                    if (m_held[i] == dwell[i]) begin
                        m_held[i] = 0;
                        m_wrap[i] = (m_pos[i] == n_out[i] - 1) ? 1 : 0;
                        m_pos[i] = (m_pos[i] + 1) % n_out[i];
                    end
                end
                m_y[i] = en ? (mask & ~(1 << m_pos[i])) : mask;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("a_y_n", int'(ifa.y_n), m_y[0]);
        chk("a_cur_addr", int'(ifa.cur_addr), m_pos[0]);
        chk("a_wrap", int'(ifa.wrap), m_wrap[0]);
        chk("a_addr_err", int'(ifa.addr_err), m_err[0]);
        chk("b_y_n", int'(ifb.y_n), m_y[1]);
        chk("b_cur_addr", int'(ifb.cur_addr), m_pos[1]);
        chk("b_wrap", int'(ifb.wrap), m_wrap[1]);
        chk("b_addr_err", int'(ifb.addr_err), m_err[1]);
    endtask

    task automatic drive(input logic r, input logic a1, input logic a2, input logic a3,
                         input logic md, input logic v, input logic [2:0] ad);
        rst_n = r; e1_n = a1; e2_n = a2; e3 = a3; mode = md; vld = v; addr = ad;
    endtask

    typedef struct {
        logic       rst_n, e1_n, e2_n, e3, mode, vld;
        logic [2:0] addr;
        logic [7:0] exp_y;
        logic [2:0] exp_cur;
    } vec_t;
    vec_t tbl[15];

    initial begin
        int wraps;
        // reset, load 5, walk 0..7, disable/enable, disable with a load pending
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 3'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5, 8'hDF, 3'd5};
        for (int i = 0; i < 8; i++)
            tbl[3 + i] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'(i), ~(8'(1) << i), 3'(i)};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'hFF, 3'd7};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h7F, 3'd7};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 8'hFF, 3'd7};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h7F, 3'd7};

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        for (int t = 0; t < 15; t++) begin
            drive(tbl[t].rst_n, tbl[t].e1_n, tbl[t].e2_n, tbl[t].e3, tbl[t].mode, tbl[t].vld, tbl[t].addr);
            cycle();
            chk($sformatf("vec%0d_y_n", t), int'(ifa.y_n), int'(tbl[t].exp_y));
            chk($sformatf("vec%0d_cur", t), int'(ifa.cur_addr), int'(tbl[t].exp_cur));
            chk($sformatf("vec%0d_err", t), int'(ifa.addr_err), 0);
        end

        // Scan from 0 with DWELL=4: one position per 4 edges, single wrap at 7->0.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0);
        cycle();
        wraps = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        for (int k = 1; k <= 35; k++) begin
            cycle();
            wraps += int'(ifa.wrap);
            chk($sformatf("scan_cur_k%0d", k), int'(ifa.cur_addr), (k / 4) % 8);
            chk($sformatf("scan_y_k%0d", k), int'(ifa.y_n), 8'hFF & ~(1 << ((k / 4) % 8)));
            chk($sformatf("scan_wrap_k%0d", k), int'(ifa.wrap), (k == 32) ? 1 : 0);
        end
        chk("scan_wrap_count", wraps, 1);

        // Load during scan restarts the dwell; no advance, no wrap.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
        cycle();
        chk("load_cur", int'(ifa.cur_addr), 3);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        for (int k = 1; k <= 4; k++) begin
            cycle();
            chk($sformatf("load_hold_k%0d", k), int'(ifa.cur_addr), (k < 4) ? 3 : 4);
            chk($sformatf("load_wrap_k%0d", k), int'(ifa.wrap), 0);
        end

        // Six-output instance: illegal address 6 in direct mode, then DWELL=1 scan wrapping 5->0.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd2);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd6);
        cycle();
        chk("b_err_pulse", int'(ifb.addr_err), 1);
        chk("b_err_cur", int'(ifb.cur_addr), 2);
        chk("a_load6_err", int'(ifa.addr_err), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        cycle();
        chk("b_err_clear", int'(ifb.addr_err), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        for (int j = 1; j <= 8; j++) begin
            cycle();
            chk($sformatf("b_scan_cur_j%0d", j), int'(ifb.cur_addr), (2 + j) % 6);
            chk($sformatf("b_scan_wrap_j%0d", j), int'(ifb.wrap), ((2 + j) % 6 == 0) ? 1 : 0);
        end

        // Reset while the six-output instance sits at 4.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        cycle();
        chk("rst_b_cur", int'(ifb.cur_addr), 0);
        chk("rst_b_y", int'(ifb.y_n), 6'h3F);
        chk("rst_b_wrap", int'(ifb.wrap), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd5);
        cycle();
        chk("b_load5_y", int'(ifb.y_n), 6'h1F);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2);
        cycle();
        chk("dis_b_cur", int'(ifb.cur_addr), 5);
        chk("dis_b_err", int'(ifb.addr_err), 0);
        chk("dis_b_y", int'(ifb.y_n), 6'h3F);

        // Randomized traffic against the reference model.
        for (int r = 0; r < 400; r++) begin
            rst_n = ($urandom_range(0, 49) != 0);
            e1_n  = ($urandom_range(0, 7) == 0);
            e2_n  = ($urandom_range(0, 7) == 0);
            e3    = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            vld   = ($urandom_range(0, 5) == 0);
            addr  = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
